router_param_xbar: RTL and testbench
====================================

Name: router_param_xbar

Overview:
- Parametrised successor to the 1-to-3 packet router: one byte-serial input port, NUM_PORTS output channels, each with its own FIFO.
- Packet format is header {len, addr}, then len payload bytes, then an even-parity (XOR) byte.
- New over the previous generation: whole-packet admission (no mid-packet stalls), dropping of illegal or oversize packets, and a saturating parity-error counter.
- Per-channel read-timeout flush is kept.

Parameters:
- DW, 8, data width; the header is {len[DW-1:2], addr[1:0]}.
- NUM_PORTS, 3, output channels, 1..4.
- FIFO_DEPTH, 16, entries per channel FIFO, power of two, >=4.
- TIMEOUT, 30, cycles vld_out may stay high unread before the channel flushes.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- din  in  DW  input byte.
- pkt_valid  in  1  din qualifier; high from header through parity byte inclusive.
- read_enb  in  NUM_PORTS  per-channel read strobe.
- dout  out  NUM_PORTS*DW  channel i occupies bits [i*DW +: DW].
- vld_out  out  NUM_PORTS  channel FIFO non-empty.
- busy  out  1  input stall; a byte is consumed only when pkt_valid=1 and busy=0.
- err  out  1  one-cycle pulse on parity mismatch.
- err_cnt  out  8  saturating count of parity errors.
- drop  out  1  one-cycle pulse when a packet is discarded.
- soft_rst  out  NUM_PORTS  one-cycle pulse when a channel is flushed by timeout.

Behaviour:
- Reset (async, any time, including mid-packet):
  - FSM goes to IDLE; all FIFOs are emptied.
  - dout=0, vld_out=0, busy=0, err=0, err_cnt=0, drop=0, soft_rst=0.
  - Timeout counters are cleared.
- Input FSM states: IDLE, CHECK, PAYLOAD, DROP. busy=1 only in CHECK.
- IDLE: when pkt_valid=1, the header is consumed and captured; parity accumulator is set to the header value.
  - If addr>=NUM_PORTS, len==0, or len+2>FIFO_DEPTH: go to DROP, with remaining = len+1.
  - Otherwise go to CHECK.
- CHECK:
  - If free[addr] >= len+2: write the header into FIFO[addr], go to PAYLOAD, remaining = len+1.
  - free = FIFO_DEPTH - count, using the registered count (conservative under same-cycle reads).
  - Otherwise stay in CHECK; the sender holds din.
- PAYLOAD: each consumed byte is written to FIFO[addr] and XORed into the accumulator; remaining is decremented.
  - pkt_valid=0 gaps hold state with no write.
  - The byte consumed when remaining==1 is the parity byte. It is written to the FIFO and compared with the accumulator.
  - On mismatch, err pulses the next cycle and err_cnt increments, saturating at 255.
  - Then return to IDLE.
  - Admission guarantees the FIFO never fills mid-packet.
- DROP: consumed bytes are discarded and remaining is decremented. After the last byte, drop pulses the next cycle and the FSM returns to IDLE.
- Channel FIFO (x NUM_PORTS): circular buffer with a count register.
  - Write and read in the same cycle are both legal.
  - A read with read_enb[i]=1 and vld_out[i]=1 loads dout[i] on the same edge, so data appears the cycle after the strobe (1-cycle latency).
  - dout holds its value when not reading.
  - A read when empty is ignored.
  - vld_out[i] = count!=0, combinational from the registered count.
- Timeout:
  - Counter i increments each cycle while vld_out[i]=1 and read_enb[i]=0.
  - It clears on any read or when the FIFO is empty.
  - On reaching TIMEOUT: FIFO i is emptied, soft_rst[i] pulses, and the counter clears.
  - If the FSM is in PAYLOAD to channel i at that moment, the remaining bytes are consumed without writing, no err is checked, and drop pulses at the end.
- A simultaneous flush and write to the same channel: the flush wins and the write is lost.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then send header 0x38 (len 14, addr 0) with 14 random payload bytes and the correct parity; read_enb[0] held high -> 16 bytes appear on dout[0] in order, one cycle after each strobe; err=0, drop=0, busy never high.
- Same packet with the parity byte XORed with 0x01 -> err pulses once, err_cnt=1; all 16 bytes still delivered. Repeat 300 times -> err_cnt=255.
- NUM_PORTS=3, header 0x13 (addr 3) -> len+1 bytes consumed with no FIFO writes, drop pulses once, all vld_out stay 0. Repeat with len 15 (0x3C, 17>16) -> dropped.
- Fill channel 1 with a len-10 packet (12 entries, unread), then send a len-4 packet to channel 1 -> busy=1 in CHECK until 2 entries are read (free=6), then the packet is accepted with no gaps.
- Leave channel 2 with data unread for 30 cycles -> soft_rst[2] pulses, vld_out[2]=0. Repeat with the flush mid-packet -> the rest of the packet is discarded and drop pulses.
- Assert resetn=0 mid-PAYLOAD -> all outputs 0 immediately; the next packet routes correctly.

Source files
------------

// File: rtl/router_param_xbar.sv
// router_param_xbar: byte-serial packet router to NUM_PORTS channel FIFOs with
// whole-packet admission, illegal/oversize drop, parity error count and read-timeout flush.
module router_param_xbar #(
    parameter int DW         = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DW-1:0]           din,
    input  logic                    pkt_valid,
    input  logic [NUM_PORTS-1:0]    read_enb,
    output logic [NUM_PORTS*DW-1:0] dout,
    output logic [NUM_PORTS-1:0]    vld_out,
    output logic                    busy,
    output logic                    err,
    output logic [7:0]              err_cnt,
    output logic                    drop,
    output logic [NUM_PORTS-1:0]    soft_rst
);
    localparam int LW = DW - 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (LW > CW ? LW : CW) + 2;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, PAYLOAD, DROP} state_t;

    state_t         r_state, w_next;
    logic [DW-1:0]  r_hdr, r_par;
    logic [1:0]     r_addr;
    logic [LW-1:0]  r_len;
    logic [LW:0]    r_rem;
    logic           r_err, r_drop;
    logic [7:0]     r_err_cnt;
    logic [CW-1:0]  w_cnt [4];
    logic [3:0]     w_flush;
    logic [LW-1:0]  w_hlen;
    logic [1:0]     w_haddr;
    logic           w_take, w_bad, w_fit, w_last, w_cur_flush;
    logic           w_wr_en, w_err_set, w_drop_set;
    logic [DW-1:0]  w_wr_data;

    assign w_hlen      = din[DW-1:2];
    assign w_haddr     = din[1:0];
    assign w_take      = pkt_valid && !busy;
    assign w_bad       = 32'(w_haddr) >= NUM_PORTS || w_hlen == '0 ||
                         XW'(w_hlen) + XW'(2) > XW'(FIFO_DEPTH);
    // free space judged on the registered count, so a same-cycle read is not credited
    assign w_fit       = XW'(FIFO_DEPTH) - XW'(w_cnt[r_addr]) >= XW'(r_len) + XW'(2);
    assign w_last      = r_rem == (LW+1)'(1);
    assign w_cur_flush = w_flush[r_addr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (pkt_valid) w_next = w_bad ? DROP : CHECK;
            CHECK:   if (w_fit) w_next = PAYLOAD;
            PAYLOAD: w_next = (w_take && w_last) ? IDLE : w_cur_flush ? DROP : PAYLOAD;
            DROP:    if (w_take && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = r_state == CHECK;
        w_wr_en    = (r_state == CHECK && w_fit) || (r_state == PAYLOAD && w_take);
        w_wr_data  = r_state == CHECK ? r_hdr : din;
        w_err_set  = r_state == PAYLOAD && w_take && w_last && !w_cur_flush && din != r_par;
        w_drop_set = w_take && w_last && (r_state == DROP || (r_state == PAYLOAD && w_cur_flush));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hdr     <= '0;
            r_par     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_rem     <= '0;
            r_err     <= 1'b0;
            r_drop    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err  <= w_err_set;
            r_drop <= w_drop_set;
            if (w_err_set && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (r_state == IDLE && pkt_valid) begin
                r_hdr  <= din;
                r_par  <= din;
                r_addr <= w_haddr;
                r_len  <= w_hlen;
                r_rem  <= {1'b0, w_hlen} + (LW+1)'(1);
            end else if ((r_state == PAYLOAD || r_state == DROP) && w_take) begin
                r_rem <= r_rem - (LW+1)'(1);
                r_par <= r_par ^ din;
            end
        end
    end

    assign err     = r_err;
    assign drop    = r_drop;
    assign err_cnt = r_err_cnt;

    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NUM_PORTS) begin : g_on
            logic [DW-1:0] r_mem [FIFO_DEPTH];
            logic [AW-1:0] r_wp, r_rp;
            logic [CW-1:0] r_cnt;
            logic [DW-1:0] r_dout;
            logic [TW-1:0] r_tmo;
            logic          r_srst;
            logic          w_vld, w_re, w_we, w_fl;

            assign w_vld = r_cnt != '0;
            assign w_re  = read_enb[c] && w_vld;
            assign w_fl  = w_vld && !read_enb[c] && r_tmo == TW'(TIMEOUT - 1);
            // a flush beats a concurrent write to the same channel
            assign w_we  = w_wr_en && r_addr == 2'(c) && !w_fl;

            always_ff @(posedge clk) begin
                if (w_we) r_mem[r_wp] <= w_wr_data;
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_wp   <= '0;
                    r_rp   <= '0;
                    r_cnt  <= '0;
                    r_dout <= '0;
                    r_tmo  <= '0;
                    r_srst <= 1'b0;
                end else begin
                    r_srst <= w_fl;
                    r_tmo  <= (!w_vld || read_enb[c] || w_fl) ? '0 : r_tmo + TW'(1);
                    if (w_re) r_dout <= r_mem[r_rp];
                    if (w_fl) begin
                        r_wp  <= '0;
                        r_rp  <= '0;
                        r_cnt <= '0;
                    end else begin
                        if (w_we) r_wp <= r_wp + AW'(1);
                        if (w_re) r_rp <= r_rp + AW'(1);
                        r_cnt <= r_cnt + CW'(w_we) - CW'(w_re);
                    end
                end
            end

            assign w_cnt[c]           = r_cnt;
            assign w_flush[c]         = w_fl;
            assign dout[c*DW +: DW]   = r_dout;
            assign vld_out[c]         = w_vld;
            assign soft_rst[c]        = r_srst;
        end else begin : g_off
            assign w_cnt[c]   = '0;
            assign w_flush[c] = 1'b0;
        end
    end
endmodule

// File: tb/tb_router_param_xbar.sv
// tb_router_param_xbar: directed scenario tasks for router_param_xbar with per-channel
// output capture; each task compares against hand-derived values.
module tb_router_param_xbar;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  din = '0;
    logic        pkt_valid = 1'b0;
    logic [2:0]  read_enb = '0;
    logic [23:0] dout;
    logic [2:0]  vld_out, soft_rst;
    logic        busy, err, drop;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int n_err = 0, n_drop = 0, n_busy = 0, n_vld2 = 0;
    int n_srst [3];
    logic [7:0] q0[$], q1[$], q2[$];
    logic [2:0] pend = '0;
    logic [7:0] pl [16];
    logic [7:0] last_par;

    router_param_xbar #(.DW(8), .NUM_PORTS(3), .FIFO_DEPTH(16), .TIMEOUT(30)) dut (
        .clk(clk), .resetn(resetn), .din(din), .pkt_valid(pkt_valid), .read_enb(read_enb),
        .dout(dout), .vld_out(vld_out), .busy(busy), .err(err), .err_cnt(err_cnt),
        .drop(drop), .soft_rst(soft_rst)
    );

    always #5 clk = ~clk;

    // capture: a strobe seen with vld_out high yields dout one cycle later
    always @(negedge clk) begin
        if (!resetn) pend = '0;
        else begin
            if (pend[0]) q0.push_back(dout[7:0]);
            if (pend[1]) q1.push_back(dout[15:8]);
            if (pend[2]) q2.push_back(dout[23:16]);
            pend = read_enb & vld_out;
        end
        if (err) n_err++;
        if (drop) n_drop++;
        if (busy) n_busy++;
        if (vld_out[2]) n_vld2++;
        for (int c = 0; c < 3; c++) if (soft_rst[c]) n_srst[c]++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        din = b;
        pkt_valid = 1'b1;
        @(negedge clk);
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL send_byte_stall got busy=1 required busy=0");
        end
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] flip);
        logic [7:0] p = hdr;
        send_byte(hdr);
        for (int k = 0; k < n; k++) begin
            send_byte(pl[k]);
            p ^= pl[k];
        end
        send_byte(p ^ flip);
        last_par = p ^ flip;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL rst_vld got %b required 000", vld_out); end
        checks++; if (dout !== 24'h0) begin errors++; $display("FAIL rst_dout got %h required 0", dout); end
        checks++; if ({busy, err, drop, soft_rst} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b required 0", {busy, err, drop, soft_rst}); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_errcnt got %h required 00", err_cnt); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_q[$];
        int b = q0.size(), e0 = n_err, d0 = n_drop, bz = n_busy;
        read_enb = 3'b001;
        for (int k = 0; k < 14; k++) pl[k] = 8'((k + 1) * 17);
        exp_q.push_back(8'h38);
        for (int k = 0; k < 14; k++) exp_q.push_back(pl[k]);
        exp_q.push_back(8'hC7);
        send_pkt(8'h38, 14, 8'h00);
        repeat (4) tick();
        read_enb = 3'b000;
        tick();
        checks++; if (q0.size() - b !== 16) begin errors++; $display("FAIL basic_len got %0d required 16", q0.size() - b); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (q0[b + k] !== exp_q[k]) begin errors++; $display("FAIL basic_byte%0d got %h required %h", k, q0[b + k], exp_q[k]); end
        end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL basic_err got %0d required 0", n_err - e0); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL basic_drop got %0d required 0", n_drop - d0); end
        checks++; if (n_busy - bz !== 1) begin errors++; $display("FAIL basic_busy_cycles got %0d required 1", n_busy - bz); end
        checks++; if (vld_out[0] !== 1'b0) begin errors++; $display("FAIL basic_drained got %b required 0", vld_out[0]); end
    endtask

    task automatic test_parity_err();
        int b = q0.size(), e0 = n_err;
        read_enb = 3'b001;
        send_pkt(8'h38, 14, 8'h01);
        repeat (4) tick();
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL perr_pulse got %0d required 1", n_err - e0); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL perr_cnt1 got %0d required 1", err_cnt); end
        checks++; if (q0.size() - b !== 16) begin errors++; $display("FAIL perr_len got %0d required 16", q0.size() - b); end
        checks++; if (q0[b + 15] !== 8'hC6) begin errors++; $display("FAIL perr_parbyte got %h required c6", q0[b + 15]); end
        for (int r = 0; r < 299; r++) send_pkt(8'h38, 14, 8'h01);
        repeat (4) tick();
        read_enb = 3'b000;
        tick();
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL perr_sat got %0d required 255", err_cnt); end
        checks++; if (n_err - e0 !== 300) begin errors++; $display("FAIL perr_pulses got %0d required 300", n_err - e0); end
        checks++; if (q0.size() - b !== 4800) begin errors++; $display("FAIL perr_total got %0d required 4800", q0.size() - b); end
    endtask

    task automatic test_drop();
        int d0 = n_drop, bz = n_busy;
        read_enb = 3'b000;
        send_byte(8'h13);
        repeat (4) send_byte(8'h5A);
        repeat (2) tick();
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL drop_early got %0d required 0", n_drop - d0); end
        send_byte(8'h5A);
        repeat (3) tick();
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL drop_addr got %0d required 1", n_drop - d0); end
        checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL drop_addr_vld got %b required 000", vld_out); end
        d0 = n_drop;
        send_byte(8'h3C);
        repeat (16) send_byte(8'hC3);
        repeat (3) tick();
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL drop_oversize got %0d required 1", n_drop - d0); end
        checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL drop_oversize_vld got %b required 000", vld_out); end
        d0 = n_drop;
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (3) tick();
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL drop_len0 got %0d required 1", n_drop - d0); end
        checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL drop_len0_vld got %b required 000", vld_out); end
        checks++; if (n_busy - bz !== 0) begin errors++; $display("FAIL drop_busy got %0d required 0", n_busy - bz); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        int b = q1.size(), bz;
        read_enb = 3'b000;
        for (int k = 0; k < 10; k++) pl[k] = 8'hA0 + 8'(k);
        exp_q.push_back(8'h29);
        for (int k = 0; k < 10; k++) exp_q.push_back(pl[k]);
        send_pkt(8'h29, 10, 8'h00);
        exp_q.push_back(last_par);
        checks++; if (vld_out[1] !== 1'b1) begin errors++; $display("FAIL bp_vld got %b required 1", vld_out[1]); end
        send_byte(8'h11);
        din = 8'hB1;
        pkt_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_hold got %b required 1", busy); end
        @(posedge clk);
        #1 read_enb = 3'b010;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_one_read got %b required 1", busy); end
        @(posedge clk);
        #1 read_enb = 3'b000;
        send_byte(8'hB1);
        bz = n_busy;
        send_byte(8'hB2);
        send_byte(8'hB3);
        send_byte(8'hB4);
        send_byte(8'h15);
        checks++; if (n_busy - bz !== 0) begin errors++; $display("FAIL bp_gap got %0d required 0", n_busy - bz); end
        exp_q.push_back(8'h11);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hB3);
        exp_q.push_back(8'hB4);
        exp_q.push_back(8'h15);
        read_enb = 3'b010;
        repeat (20) tick();
        read_enb = 3'b000;
        tick();
        checks++; if (q1.size() - b !== 18) begin errors++; $display("FAIL bp_len got %0d required 18", q1.size() - b); end
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (q1[b + k] !== exp_q[k]) begin errors++; $display("FAIL bp_byte%0d got %h required %h", k, q1[b + k], exp_q[k]); end
        end
        checks++; if (vld_out[1] !== 1'b0) begin errors++; $display("FAIL bp_drained got %b required 0", vld_out[1]); end
    endtask

    task automatic test_timeout();
        int s0 = n_srst[2], v0 = n_vld2, d0 = n_drop, e0 = n_err, w = 0;
        read_enb = 3'b000;
        pl[0] = 8'hA5;
        send_pkt(8'h06, 1, 8'h00);
        while (n_srst[2] == s0 && w < 80) begin tick(); w++; end
        repeat (2) tick();
        checks++; if (n_srst[2] - s0 !== 1) begin errors++; $display("FAIL tmo_pulse got %0d required 1", n_srst[2] - s0); end
        checks++; if (n_vld2 - v0 !== 30) begin errors++; $display("FAIL tmo_vld_cycles got %0d required 30", n_vld2 - v0); end
        checks++; if (vld_out[2] !== 1'b0) begin errors++; $display("FAIL tmo_vld got %b required 0", vld_out[2]); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL tmo_nodrop got %0d required 0", n_drop - d0); end
        s0 = n_srst[2];
        w = 0;
        send_byte(8'h2A);
        send_byte(8'h01);
        while (n_srst[2] == s0 && w < 80) begin tick(); w++; end
        tick();
        checks++; if (n_srst[2] - s0 !== 1) begin errors++; $display("FAIL tmo_mid_pulse got %0d required 1", n_srst[2] - s0); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL tmo_mid_early got %0d required 0", n_drop - d0); end
        for (int k = 0; k < 9; k++) send_byte(8'h40 + 8'(k));
        send_byte(8'h00);
        repeat (2) tick();
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL tmo_mid_drop got %0d required 1", n_drop - d0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL tmo_mid_err got %0d required 0", n_err - e0); end
        checks++; if (vld_out[2] !== 1'b0) begin errors++; $display("FAIL tmo_mid_vld got %b required 0", vld_out[2]); end
    endtask

    task automatic test_reset_mid();
        int b, e0;
        read_enb = 3'b000;
        for (int k = 0; k < 14; k++) pl[k] = 8'((k + 1) * 17);
        send_byte(8'h38);
        for (int k = 0; k < 5; k++) send_byte(pl[k]);
        din = 8'h77;
        pkt_valid = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL mrst_vld got %b required 000", vld_out); end
        checks++; if (dout !== 24'h0) begin errors++; $display("FAIL mrst_dout got %h required 0", dout); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL mrst_errcnt got %h required 00", err_cnt); end
        checks++; if ({busy, err, drop, soft_rst} !== 6'b0) begin errors++; $display("FAIL mrst_flags got %b required 0", {busy, err, drop, soft_rst}); end
        pkt_valid = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        b = q1.size();
        e0 = n_err;
        read_enb = 3'b010;
        pl[0] = 8'h10;
        pl[1] = 8'h20;
        pl[2] = 8'h30;
        send_pkt(8'h0D, 3, 8'h00);
        repeat (4) tick();
        read_enb = 3'b000;
        tick();
        checks++; if (q1.size() - b !== 5) begin errors++; $display("FAIL mrst_len got %0d required 5", q1.size() - b); end
        checks++; if ({q1[b], q1[b+1], q1[b+2], q1[b+3], q1[b+4]} !== 40'h0D1020300D) begin
            errors++; $display("FAIL mrst_bytes got %h required 0d1020300d", {q1[b], q1[b+1], q1[b+2], q1[b+3], q1[b+4]}); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL mrst_err got %0d required 0", n_err - e0); end
        checks++; if (vld_out !== 3'b000) begin errors++; $display("FAIL mrst_after_vld got %b required 000", vld_out); end
    endtask

    initial begin
        for (int c = 0; c < 3; c++) n_srst[c] = 0;
        test_reset();
        test_basic();
        test_parity_err();
        test_drop();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
